gsensor_bus_arbiter: RTL and testbench
======================================

GSENSOR_BUS_ARBITER -- requirements
Module: gsensor_bus_arbiter

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 8: idle cycles inserted between bus owners (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum grant hold in cycles (16-bit).
REQ-003 The block SHALL have port clk, input, 1: the single clock, rising-edge (50 MHz system clock).
REQ-004 The block SHALL have port reset_n, input, 1: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port spi_req, input, 1: request from the accelerometer SPI master.
REQ-006 The block SHALL have port spi_gnt, output, 1: SPI master owns the shared SCLK/SDAT bus.
REQ-007 The block SHALL have port i2c_req, input, 1: request from the EEPROM I2C master.
REQ-008 The block SHALL have port i2c_gnt, output, 1: I2C master owns the bus.
REQ-009 The block SHALL have port spi_sclk_in, input, 1: SPI master clock.
REQ-010 The block SHALL have port spi_cs_n_in, input, 1: SPI master chip select.
REQ-011 The block SHALL have port i2c_scl_in, input, 1: I2C master clock.
REQ-012 The block SHALL have port sclk_out, output, 1: clock to the shared I2C_SCLK pin.
REQ-013 The block SHALL have port cs_n_out, output, 1: accelerometer chip select pin.
REQ-014 The block SHALL have port sel_i2c, output, 1: high while I2C owns the bus.
REQ-015 The block SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 The block SHALL have port err_clr, input, 1: clears timeout_err.
REQ-017 The block SHALL have port timeout_err, output, 1: sticky flag, grant forcibly revoked.

Function
REQ-018 The FSM SHALL have the states IDLE, SPI, I2C and GUARD, plus a last-served register (last).
REQ-019 In IDLE with a single request sampled at edge E, the matching gnt SHALL go high at E (one-cycle request-to-grant latency, registered).
REQ-020 In IDLE with both requests sampled, the block SHALL grant the requester not equal to last (round-robin); last SHALL update on every grant.
REQ-021 In SPI/I2C, gnt SHALL stay high while the owner's req is high; an edge sampling req low SHALL clear gnt and enter GUARD with guard counter = GUARD_CYCLES-1.
REQ-022 GUARD SHALL decrement each edge; at counter 0 the next state SHALL be chosen by the IDLE rules (direct grant if a request is pending, else IDLE), so GUARD occupies exactly GUARD_CYCLES cycles.
REQ-023 Requests during GUARD SHALL NOT be granted early; a request withdrawn before grant SHALL be ignored.
REQ-024 sclk_out SHALL be combinational from the state register: spi_sclk_in in SPI, i2c_scl_in in I2C, 1 otherwise.
REQ-025 cs_n_out SHALL equal spi_cs_n_in in SPI and 1 otherwise; sel_i2c SHALL be 1 only in I2C.
REQ-026 spi_gnt and i2c_gnt SHALL never both be 1.
REQ-027 err_clr SHALL clear timeout_err at the next edge; a simultaneous set SHALL win.

Reset
REQ-028 Asserting reset_n low SHALL immediately force: state IDLE, both gnt 0, sclk_out 1, cs_n_out 1, sel_i2c 0, busy 0, timeout_err 0, last=I2C (SPI wins the first tie), counters 0; assertion mid-grant SHALL abort with no GUARD phase.

Configuration
REQ-029 With macro GSENSOR_ARB_TIMEOUT_EN defined, a hold counter SHALL count cycles in SPI/I2C; at TIMEOUT_CYCLES it SHALL force GUARD, clear gnt, and set timeout_err, and the revoked requester SHALL be locked out until its req has been sampled low at least once.
REQ-030 Without GSENSOR_ARB_TIMEOUT_EN, no hold counter or lockout SHALL exist, a grant SHALL be held indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover: reset, then spi_req=1 at edge 1 -> spi_gnt=1 after edge 1, sclk_out follows spi_sclk_in, cs_n_out follows spi_cs_n_in, sel_i2c=0.
REQ-032 The bench SHALL cover: both req rising together after reset -> SPI granted; SPI drops req, i2c_req still high -> i2c_gnt rises exactly 8 edges later, sclk_out=1 during the gap.
REQ-033 The bench SHALL cover: both requesters holding req continuously, each releasing for 1 cycle after 20 cycles of ownership -> grants alternate SPI, I2C, SPI, never overlapping.
REQ-034 The bench SHALL cover: reset_n pulsed low mid-I2C grant -> i2c_gnt=0, sclk_out=1, sel_i2c=0 within the same cycle, with no clock edge required.
REQ-035 The bench SHALL cover, with GSENSOR_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=100: SPI held for 100 cycles -> spi_gnt falls and timeout_err=1; SPI is not regranted until req drops; err_clr -> timeout_err=0.
REQ-036 The bench SHALL cover, without GSENSOR_ARB_TIMEOUT_EN: the same 100-cycle stimulus -> spi_gnt stays 1 and timeout_err stays 0.

Source files
------------

// File: rtl/gsensor_bus_arbiter.sv
// gsensor_bus_arbiter
// Shares one SCLK/SDAT pin pair between the accelerometer SPI master and the
// EEPROM I2C master. Arbitration is round-robin on ties. A fixed idle guard
// gap separates any two bus owners.
// Optional feature macro: GSENSOR_ARB_TIMEOUT_EN. When it is defined, the
// block revokes a grant held for TIMEOUT_CYCLES cycles, raises a sticky
// timeout_err, and locks the revoked master out until it drops its request.
module gsensor_bus_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset_n,
   input  logic spi_req,
   output logic spi_gnt,
   input  logic i2c_req,
   output logic i2c_gnt,
   input  logic spi_sclk_in,
   input  logic spi_cs_n_in,
   input  logic i2c_scl_in,
   output logic sclk_out,
   output logic cs_n_out,
   output logic sel_i2c,
   output logic busy,
   input  logic err_clr,
   output logic timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPI   = 2'd1,
      I2C   = 2'd2,
      GUARD = 2'd3
   } state_t;

   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

   state_t     state;
   logic       last_i2c;   // 1: I2C was served last, so SPI wins the next tie
   logic [7:0] guard_cnt;

   logic spi_eff;
   logic i2c_eff;
   logic pick_spi;
   logic pick_i2c;

`ifdef GSENSOR_ARB_TIMEOUT_EN
   localparam logic [15:0] HOLD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] hold_cnt;
   logic        spi_lock;
   logic        i2c_lock;
   logic        err_flag;

   assign spi_eff     = spi_req & ~spi_lock;
   assign i2c_eff     = i2c_req & ~i2c_lock;
   assign timeout_err = err_flag;
`else
   logic unused_cfg;

   assign spi_eff     = spi_req;
   assign i2c_eff     = i2c_req;
   assign timeout_err = 1'b0;
   assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

   // Arbitration choice: a lone request wins, and a tie goes to the master
   // that was not served last.
   always_comb begin
      pick_spi = spi_eff & (~i2c_eff | last_i2c);
      pick_i2c = i2c_eff & (~spi_eff | ~last_i2c);
   end

   // Ownership FSM with registered grants, guard counter and round-robin state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         spi_gnt   <= 1'b0;
         i2c_gnt   <= 1'b0;
         last_i2c  <= 1'b1;
         guard_cnt <= '0;
`ifdef GSENSOR_ARB_TIMEOUT_EN
         hold_cnt  <= '0;
         spi_lock  <= 1'b0;
         i2c_lock  <= 1'b0;
         err_flag  <= 1'b0;
`endif
      end else begin
`ifdef GSENSOR_ARB_TIMEOUT_EN
         // Lockout ends once the request has been seen low. A clear is
         // overridden below when a timeout fires on the same edge.
         if (!spi_req) spi_lock <= 1'b0;
         if (!i2c_req) i2c_lock <= 1'b0;
         if (err_clr)  err_flag <= 1'b0;
`endif
         case (state)
            // IDLE and the final GUARD cycle share the same grant decision.
            IDLE, GUARD: begin
               if (state == IDLE || guard_cnt == '0) begin
                  if (pick_spi) begin
                     state    <= SPI;
                     spi_gnt  <= 1'b1;
                     last_i2c <= 1'b0;
`ifdef GSENSOR_ARB_TIMEOUT_EN
                     hold_cnt <= '0;
`endif
                  end else if (pick_i2c) begin
                     state    <= I2C;
                     i2c_gnt  <= 1'b1;
                     last_i2c <= 1'b1;
`ifdef GSENSOR_ARB_TIMEOUT_EN
                     hold_cnt <= '0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  guard_cnt <= guard_cnt - 8'd1;
               end
            end
            SPI: begin
               if (!spi_req) begin
                  state     <= GUARD;
                  spi_gnt   <= 1'b0;
                  guard_cnt <= GUARD_LOAD;
               end
`ifdef GSENSOR_ARB_TIMEOUT_EN
               else if (hold_cnt == HOLD_LIMIT) begin
                  state     <= GUARD;
                  spi_gnt   <= 1'b0;
                  guard_cnt <= GUARD_LOAD;
                  spi_lock  <= 1'b1;
                  err_flag  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
`endif
            end
            I2C: begin
               if (!i2c_req) begin
                  state     <= GUARD;
                  i2c_gnt   <= 1'b0;
                  guard_cnt <= GUARD_LOAD;
               end
`ifdef GSENSOR_ARB_TIMEOUT_EN
               else if (hold_cnt == HOLD_LIMIT) begin
                  state     <= GUARD;
                  i2c_gnt   <= 1'b0;
                  guard_cnt <= GUARD_LOAD;
                  i2c_lock  <= 1'b1;
                  err_flag  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pin muxing decoded directly from the state register, so that reset
   // parks the pins with no clock edge.
   always_comb begin
      sclk_out = 1'b1;
      cs_n_out = 1'b1;
      sel_i2c  = 1'b0;
      busy     = (state != IDLE);
      case (state)
         SPI: begin
            sclk_out = spi_sclk_in;
            cs_n_out = spi_cs_n_in;
         end
         I2C: begin
            sclk_out = i2c_scl_in;
            sel_i2c  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_gsensor_bus_arbiter.sv
// tb_gsensor_bus_arbiter
// Self-checking bench for gsensor_bus_arbiter (GUARD_CYCLES=8, TIMEOUT_CYCLES=100).
// Expected grant/error values are queued with each stimulus cycle and are
// compared after the following clock edge. Timeout expectations follow
// GSENSOR_ARB_TIMEOUT_EN.
module tb_gsensor_bus_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic spi_req = 1'b0;
   logic i2c_req = 1'b0;
   logic spi_sclk_in = 1'b0;
   logic spi_cs_n_in = 1'b1;
   logic i2c_scl_in = 1'b0;
   logic err_clr = 1'b0;
   logic spi_gnt, i2c_gnt, sclk_out, cs_n_out, sel_i2c, busy, timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string tag;
      logic  spi;
      logic  i2c;
      logic  err;
   } exp_t;

   exp_t sb[$];

   gsensor_bus_arbiter #(
      .GUARD_CYCLES   (8),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_req     (spi_req),
      .spi_gnt     (spi_gnt),
      .i2c_req     (i2c_req),
      .i2c_gnt     (i2c_gnt),
      .spi_sclk_in (spi_sclk_in),
      .spi_cs_n_in (spi_cs_n_in),
      .i2c_scl_in  (i2c_scl_in),
      .sclk_out    (sclk_out),
      .cs_n_out    (cs_n_out),
      .sel_i2c     (sel_i2c),
      .busy        (busy),
      .err_clr     (err_clr),
      .timeout_err (timeout_err)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   // Watchdog so that the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1);
   end

   task automatic check(input string tag, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Queue the expectation, let one edge happen, then score the DUT outputs.
   task automatic cycle(input string tag, input logic e_spi, input logic e_i2c, input logic e_err);
      exp_t e;
      e.tag = tag;
      e.spi = e_spi;
      e.i2c = e_i2c;
      e.err = e_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, "_spi_gnt"}, spi_gnt, e.spi);
      check({e.tag, "_i2c_gnt"}, i2c_gnt, e.i2c);
      check({e.tag, "_err"}, timeout_err, e.err);
      check({e.tag, "_excl"}, spi_gnt & i2c_gnt, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #2;
      check({tag, "_spi_gnt"}, spi_gnt, 1'b0);
      check({tag, "_i2c_gnt"}, i2c_gnt, 1'b0);
      check({tag, "_sclk"}, sclk_out, 1'b1);
      check({tag, "_cs_n"}, cs_n_out, 1'b1);
      check({tag, "_sel"}, sel_i2c, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_err"}, timeout_err, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // One requester owns the bus for 20 cycles, then drops its request for a
   // single cycle while the other keeps requesting; the guard gap follows.
   task automatic own_then_release(input string tag, input logic is_spi);
      for (int i = 0; i < 20; i++) cycle({tag, "_own"}, is_spi, ~is_spi, 1'b0);
      if (is_spi) spi_req = 1'b0; else i2c_req = 1'b0;
      cycle({tag, "_rel"}, 1'b0, 1'b0, 1'b0);
      spi_req = 1'b1;
      i2c_req = 1'b1;
      for (int i = 0; i < 7; i++) cycle({tag, "_gap"}, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      do_reset("rst0");

      // Single SPI request: grant after one edge, pins follow the SPI master
      spi_req = 1'b1;
      cycle("s1_grant", 1'b1, 1'b0, 1'b0);
      spi_sclk_in = 1'b0; i2c_scl_in = 1'b1; #1;
      check("s1_sclk_lo", sclk_out, 1'b0);
      spi_sclk_in = 1'b1; i2c_scl_in = 1'b0; #1;
      check("s1_sclk_hi", sclk_out, 1'b1);
      spi_cs_n_in = 1'b0; #1;
      check("s1_cs_lo", cs_n_out, 1'b0);
      spi_cs_n_in = 1'b1; #1;
      check("s1_cs_hi", cs_n_out, 1'b1);
      check("s1_sel", sel_i2c, 1'b0);
      check("s1_busy", busy, 1'b1);
      spi_req = 1'b0;

      // Tie after reset goes to SPI; I2C follows exactly 8 edges after release
      do_reset("rst1");
      spi_req = 1'b1;
      i2c_req = 1'b1;
      for (int i = 0; i < 4; i++) cycle("s2_tie", 1'b1, 1'b0, 1'b0);
      spi_req = 1'b0;
      spi_sclk_in = 1'b0;
      i2c_scl_in = 1'b0;
      cycle("s2_rel", 1'b0, 1'b0, 1'b0);
      check("s2_rel_sclk", sclk_out, 1'b1);
      for (int i = 0; i < 7; i++) begin
         cycle("s2_gap", 1'b0, 1'b0, 1'b0);
         check("s2_gap_sclk", sclk_out, 1'b1);
         check("s2_gap_busy", busy, 1'b1);
      end
      cycle("s2_i2c", 1'b0, 1'b1, 1'b0);
      check("s2_sel", sel_i2c, 1'b1);
      check("s2_sclk_i2c", sclk_out, 1'b0);
      check("s2_cs_n", cs_n_out, 1'b1);

      // Reset mid-I2C grant: outputs park at once, with no clock edge
      #5;
      reset_n = 1'b0;
      #1;
      check("s4_i2c_gnt", i2c_gnt, 1'b0);
      check("s4_sclk", sclk_out, 1'b1);
      check("s4_sel", sel_i2c, 1'b0);
      check("s4_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      // No guard gap after the abort: the held I2C request is granted at once
      cycle("s4_nogap", 1'b0, 1'b1, 1'b0);
      i2c_req = 1'b0;

      // Continuous requesters alternate SPI, I2C, SPI
      do_reset("rst2");
      spi_req = 1'b1;
      i2c_req = 1'b1;
      own_then_release("s3_a_spi", 1'b1);
      own_then_release("s3_b_i2c", 1'b0);
      for (int i = 0; i < 3; i++) cycle("s3_c_spi", 1'b1, 1'b0, 1'b0);
      spi_req = 1'b0;
      i2c_req = 1'b0;

      // A single 100-cycle SPI hold
      do_reset("rst3");
      spi_req = 1'b1;
      for (int k = 1; k <= 116; k++) begin
         err_clr = (k == 101 || k == 116);
`ifdef GSENSOR_ARB_TIMEOUT_EN
         if (k <= 100)      cycle("s5_hold", 1'b1, 1'b0, 1'b0);
         else if (k <= 115) cycle("s5_revoked", 1'b0, 1'b0, 1'b1);
         else               cycle("s5_errclr", 1'b0, 1'b0, 1'b0);
`else
         cycle("s5_hold", 1'b1, 1'b0, 1'b0);
`endif
      end
      err_clr = 1'b0;
`ifdef GSENSOR_ARB_TIMEOUT_EN
      check("s5_locked_idle", busy, 1'b0);
      spi_req = 1'b0;
      cycle("s5_drop", 1'b0, 1'b0, 1'b0);
      spi_req = 1'b1;
      cycle("s5_regrant", 1'b1, 1'b0, 1'b0);
`else
      check("s5_still_busy", busy, 1'b1);
`endif
      spi_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
